// File: rtl/add_sub_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_sub_seq_if
//  Brief    : Operand/result handshake bundle for add_sub_seq. The optional
//             sat signal exists only when ADD_SUB_SEQ_SAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface add_sub_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       op;
`ifdef ADD_SUB_SEQ_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, op, out_ready,
`ifdef ADD_SUB_SEQ_SAT_EN
        output sat,
`endif
        input  in_ready, out_valid, out, carry, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, op, out_ready,
`ifdef ADD_SUB_SEQ_SAT_EN
        input  sat,
`endif
        output in_ready, out_valid, out, carry, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/add_sub_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_sub_seq
//  Brief    : Multi-cycle add/sub/compare unit, CHUNK bits per cycle through a
//             ripple carry. Optional saturation: define ADD_SUB_SEQ_SAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    add_sub_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("add_sub_seq: CHUNK must divide WIDTH and be <= WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q, ovf_q, zero_q;
`ifdef ADD_SUB_SEQ_SAT_EN
    logic             sat_q;
`endif

    logic             w_accept, w_step, w_last, w_flag_load;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_csum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    assign w_last = (cnt_q == CW'(NCHUNK - 1));
    assign w_base = 32'(cnt_q) * 32'(CHUNK);
    assign {w_cout, w_csum} = {1'b0, a_q[w_base +: CHUNK]}
                            + {1'b0, b_q[w_base +: CHUNK]}
                            + {{CHUNK{1'b0}}, c_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Flags are registered one cycle after the last chunk lands in sum_q.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_flag_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (w_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    w_flag_load = 1'b1;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        w_result = sum_q;
        case (op_q)
            2'b10:   w_result = {{(WIDTH-1){1'b0}}, sum_q[WIDTH-1] ^ w_ovf};
            2'b11:   w_result = {{(WIDTH-1){1'b0}}, ~c_q};
            default: begin
`ifdef ADD_SUB_SEQ_SAT_EN
                if (sat_q && w_ovf) begin
                    w_result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            op_q    <= 2'b00;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef ADD_SUB_SEQ_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                // Subtract and both compares run as A + ~B + 1.
                a_q   <= bus.in1;
                b_q   <= (bus.op != 2'b00) ? ~bus.in2 : bus.in2;
                c_q   <= (bus.op != 2'b00);
                op_q  <= bus.op;
                cnt_q <= '0;
`ifdef ADD_SUB_SEQ_SAT_EN
                sat_q <= bus.sat;
`endif
            end else if (w_step) begin
                sum_q[w_base +: CHUNK] <= w_csum;
                c_q   <= w_cout;
                cnt_q <= cnt_q + 1'b1;
            end
            if (w_flag_load) begin
                out_q   <= w_result;
                carry_q <= c_q;
                ovf_q   <= w_ovf;
                zero_q  <= (w_result == '0);
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_seq
//  Brief    : Self-checking bench for add_sub_seq (WIDTH=64, CHUNK=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sub_seq;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int LAT   = WIDTH / CHUNK + 1;
`ifdef ADD_SUB_SEQ_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif
    localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] SMIN = -SMAX - 65'sd1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_sub_seq_if #(.WIDTH(WIDTH)) bus ();

    add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    // Reference: exact integer arithmetic on 65-bit values.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] op, input logic s,
                                  output logic [63:0] r, output logic c,
                                  output logic v, output logic z);
        logic signed [64:0] sa, sb, sr;
        logic [64:0] ur;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        if (op == 2'b00) begin
            ur = {1'b0, a} + {1'b0, b};
            c  = ur[64];
            sr = sa + sb;
            r  = ur[63:0];
        end else begin
            c  = (a >= b);
            sr = sa - sb;
            r  = a - b;
        end
        v = (sr > SMAX) || (sr < SMIN);
        if (op == 2'b10) r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        if (op == 2'b11) r = (a < b) ? 64'd1 : 64'd0;
        if (SAT_BUILD && s && v && op[1] == 1'b0)
            r = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        z = (r == 64'd0);
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            3:       v = {48'd0, 16'(($urandom))};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive_in(input logic valid, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, input logic s);
        bus.in_valid = valid;
        bus.in1      = a;
        bus.in2      = b;
        bus.op       = op;
`ifdef ADD_SUB_SEQ_SAT_EN
        bus.sat      = s;
`else
        if (s) bus.op = op;
`endif
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic s, input int hold);
        logic [63:0] er;
        logic ec, ev, ez;
        int k;
        model(a, b, op, s, er, ec, ev, ez);
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        check({tag, "/ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive_in(1'b1, a, b, op, s);
        @(posedge clk); #1;
        drive_in(1'b0, rnd64(), rnd64(), 2'($urandom), 1'($urandom));
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        check({tag, "/latency"}, 64'(k), 64'(LAT));
        check({tag, "/out"}, bus.out, er);
        check({tag, "/carry"}, 64'(bus.carry), 64'(ec));
        check({tag, "/ovf"}, 64'(bus.overflow), 64'(ev));
        check({tag, "/zero"}, 64'(bus.zero), 64'(ez));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_in(1'b1, rnd64(), rnd64(), 2'($urandom), 1'($urandom));
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            check({tag, "/hold_out"}, bus.out, er);
            check({tag, "/hold_flags"}, {61'd0, bus.carry, bus.overflow, bus.zero}, {61'd0, ec, ev, ez});
            check({tag, "/hold_vld_rdy"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "/post_vld_rdy"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        check({tag, "/post_out"}, bus.out, er);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        #1;
        check("reset/out", bus.out, 64'd0);
        check("reset/vld_rdy", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        check("reset/flags", {61'd0, bus.carry, bus.overflow, bus.zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 0);
        run_op("sub_neg",  64'd5, 64'd7, 2'b01, 1'b0, 0);
        run_op("slt",      64'h8000_0000_0000_0000, 64'd1, 2'b10, 1'b0, 0);
        run_op("ult",      64'h8000_0000_0000_0000, 64'd1, 2'b11, 1'b0, 0);
        run_op("sub_eq",   64'h1234, 64'h1234, 2'b01, 1'b0, 0);
        run_op("add_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 0);
        run_op("add_sat",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 0);
        run_op("sub_sat",  64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1, 0);
        run_op("slt_sat",  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b1, 0);
        run_op("stall",    64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 2'b01, 1'b0, 3);
        run_op("after_stall", 64'd100, 64'd23, 2'b00, 1'b0, 0);

        for (int i = 0; i < 24; i++)
            run_op("rand", rnd64(), rnd64(), 2'($urandom), 1'($urandom), $urandom_range(0, 2));

        // Abort an operation two cycles into BUSY.
        @(negedge clk);
        drive_in(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h1111_1111_1111_1111, 2'b00, 1'b0);
        @(posedge clk); #1;
        drive_in(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort/out", bus.out, 64'd0);
        check("abort/vld_rdy", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
        end
        check("abort/no_stale", 64'(seen), 64'd0);
        run_op("after_abort", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 2'b10, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
